// File: rtl/hgo_obs_port.sv
// hgo_obs_port: observation-port controller for the HGO_Q* debug pads.
// Each of NUM_PADS pads selects one of NUM_SRC single-bit sources.
// Modes: 0 direct (combinational), 1 registered, 2 snapshot serializer, 3 as 1.
// Build option: define HGO_OBS_SNAP_EN to include the snapshot serializer.
// Without it, mode 2 decodes as mode 1 and the snapshot outputs are tied low.

// Per-pad source selector. Select codes at or above NUM_SRC read as 0.
module hgo_obs_pad_sel #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_src,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_bit
);
    localparam int SRC_P = 1 << SEL_W;

    logic [SRC_P-1:0] w_src_pad;

    // Zero-extend the source vector so every select code maps to a defined bit
    generate
        if (SRC_P > NUM_SRC) begin : g_pad
            assign w_src_pad = {{(SRC_P-NUM_SRC){1'b0}}, i_src};
        end else begin : g_nopad
            assign w_src_pad = i_src;
        end
    endgenerate

    assign o_bit = w_src_pad[i_sel];
endmodule

module hgo_obs_port #(
    parameter int NUM_PADS = 2,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = $clog2(NUM_SRC),
    parameter int SNAP_W   = 80
) (
    input  logic                      clk_obs,
    input  logic                      HGO_RSTN,
    input  logic [1:0]                i_mode,
    input  logic [NUM_PADS*SEL_W-1:0] i_sel,
    input  logic [NUM_SRC-1:0]        i_src,
    input  logic                      i_snap_req,
    input  logic [SNAP_W-1:0]         i_snap_data,
    input  logic                      i_ovf_clr,
    output logic [NUM_PADS-1:0]       o_pad,
    output logic                      o_snap_busy,
    output logic                      o_snap_ovf
);
    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clk_obs edges later
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Two-flop release synchronizer for the pad reset
    always_ff @(posedge clk_obs or negedge HGO_RSTN) begin
        if (!HGO_RSTN) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Configuration shadow
    // ------------------------------------------------------------------
    logic [1:0]                r_mode_sh;
    logic [NUM_PADS*SEL_W-1:0] r_sel_sh;
    logic                      w_idle;
    logic                      w_cfg_chg;
    logic                      w_direct;
    logic                      w_snap_mode;
    logic                      w_shift;
    logic                      w_ser_bit;

    // A config change is only taken while the serializer is idle; it has
    // priority over a new snapshot request so a deferred mode switch lands
    // in the gap after the running frame instead of being starved.
    assign w_cfg_chg = w_idle && ((i_mode != r_mode_sh) || (i_sel != r_sel_sh));

    // Shadow register for mode and per-pad selects
    always_ff @(posedge clk_obs or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mode_sh <= 2'd1;
            r_sel_sh  <= '0;
        end else if (w_cfg_chg) begin
            r_mode_sh <= i_mode;
            r_sel_sh  <= i_sel;
        end
    end

    assign w_direct = (r_mode_sh == 2'd0);

    // ------------------------------------------------------------------
    // Per-pad source selection and registered path
    // ------------------------------------------------------------------
    logic [NUM_PADS-1:0] w_sel_bit;
    logic [NUM_PADS-1:0] r_pad_q;
    logic [NUM_PADS-1:0] w_pad;

    generate
        for (genvar k = 0; k < NUM_PADS; k++) begin : g_lane
            hgo_obs_pad_sel #(
                .NUM_SRC (NUM_SRC),
                .SEL_W   (SEL_W)
            ) u_sel (
                .i_src (i_src),
                .i_sel (r_sel_sh[k*SEL_W +: SEL_W]),
                .o_bit (w_sel_bit[k])
            );
        end
    endgenerate

    // Registered pads; a shadow change forces one break cycle of zeros
    always_ff @(posedge clk_obs or negedge w_rst_n) begin
        if (!w_rst_n)       r_pad_q <= '0;
        else if (w_cfg_chg) r_pad_q <= '0;
        else                r_pad_q <= w_sel_bit;
    end

`ifdef HGO_OBS_SNAP_EN
    // ------------------------------------------------------------------
    // Snapshot serializer
    // ------------------------------------------------------------------
    localparam int CNT_W = (SNAP_W > 1) ? $clog2(SNAP_W) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } snap_st_e;

    snap_st_e          r_st;
    snap_st_e          w_st_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [SNAP_W-1:0] r_shreg;
    logic              r_ovf;
    logic              w_accept;

    assign w_snap_mode = (r_mode_sh == 2'd2);
    assign w_idle      = (r_st == S_IDLE);
    assign w_shift     = (r_st == S_SHIFT);
    assign w_accept    = w_idle && w_snap_mode && i_snap_req && !w_cfg_chg;

    // Serializer state register
    always_ff @(posedge clk_obs or negedge w_rst_n) begin
        if (!w_rst_n) r_st <= S_IDLE;
        else          r_st <= w_st_nxt;
    end

    // Serializer next state: run one frame per accepted request
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            S_IDLE:  if (w_accept) w_st_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_st_nxt = S_IDLE;
            default: w_st_nxt = S_IDLE;
        endcase
    end

    // Capture on accept, then shift MSB-first while counting down the frame
    always_ff @(posedge clk_obs or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= i_snap_data;
            r_cnt   <= CNT_W'(SNAP_W - 1);
        end else if (w_shift) begin
            r_shreg <= {r_shreg[SNAP_W-2:0], 1'b0};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sticky overflow: request seen mid-frame; set beats clear
    always_ff @(posedge clk_obs or negedge w_rst_n) begin
        if (!w_rst_n)                  r_ovf <= 1'b0;
        else if (w_shift && i_snap_req) r_ovf <= 1'b1;
        else if (i_ovf_clr)             r_ovf <= 1'b0;
    end

    assign w_ser_bit   = r_shreg[SNAP_W-1];
    assign o_snap_busy = w_shift;
    assign o_snap_ovf  = r_ovf;
`else
    logic w_unused_snap;

    assign w_snap_mode   = 1'b0;
    assign w_idle        = 1'b1;
    assign w_shift       = 1'b0;
    assign w_ser_bit     = 1'b0;
    assign o_snap_busy   = 1'b0;
    assign o_snap_ovf    = 1'b0;
    assign w_unused_snap = ^{i_snap_req, i_snap_data, i_ovf_clr};
`endif

    // ------------------------------------------------------------------
    // Pad output mux
    // ------------------------------------------------------------------
    // Frame on pads 0/1 while shifting; otherwise direct or registered path
    always_comb begin
        w_pad = '0;
        if (w_shift) begin
            w_pad    = r_pad_q;
            w_pad[0] = w_ser_bit;
            w_pad[1] = 1'b1;
        end else if (w_direct) begin
            w_pad = w_sel_bit;
        end else begin
            w_pad = r_pad_q;
            if (w_snap_mode) w_pad[1:0] = 2'b00;
        end
    end

    assign o_pad = w_pad;
endmodule
